spatial_mac_array_4x4: RTL and testbench

- 4x4 spatial array of 16 independent multiply-accumulate processing elements (PEs).
- Every clock, each PE multiplies its own weight by its own input and adds the product into a private 32-bit accumulator.
- Used as the compute core of a small spatial accelerator. Weights and activations are presented in parallel by upstream logic; accumulators are read directly by downstream logic.

---
 rtl/spatial_mac_array_4x4_pkg.sv | 23 ++
 rtl/spatial_mac_array_4x4_pe.sv | 37 +++
 rtl/spatial_mac_array_4x4.sv | 31 +++
 tb/tb_spatial_mac_array_4x4.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/spatial_mac_array_4x4_pkg.sv
// ---------------------------------------------------------------------------
// spatial_mac_array_4x4_pkg : shared sizes and element types for the MAC array
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spatial_mac_array_4x4_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ACC_W-1:0]  acc_t;

    // Full-width unsigned product; a 16x16 multiply always fits in 32 bits.
    function automatic acc_t mul_full(input data_t a, input data_t b);
        mul_full = acc_t'(a) * acc_t'(b);
    endfunction

endpackage : spatial_mac_array_4x4_pkg

`default_nettype wire

// File: rtl/spatial_mac_array_4x4_pe.sv
// ---------------------------------------------------------------------------
// mac_pe : one multiply-accumulate element with asynchronous active-low clear
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mac_pe
    import spatial_mac_array_4x4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  data_t w,
    input  data_t x,
    output acc_t  acc
);

    acc_t acc_q;
    acc_t acc_d;

    // Add wraps modulo 2^ACC_W by construction.
    always_comb begin
        acc_d = acc_q + mul_full(w, x);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule : mac_pe

`default_nettype wire

// File: rtl/spatial_mac_array_4x4.sv
// ---------------------------------------------------------------------------
// spatial_mac_array_4x4 : 4x4 array of independent MAC elements, PE i = 4r+c
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spatial_mac_array_4x4
    import spatial_mac_array_4x4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  data_t weight  [N][N],
    input  data_t inputt  [N*N],
    output acc_t  outputt [N*N]
);

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            mac_pe u_pe (
                .clk (clk),
                .rst (rst),
                .w   (weight[r][c]),
                .x   (inputt[N*r + c]),
                .acc (outputt[N*r + c])
            );
        end
    end

endmodule : spatial_mac_array_4x4

`default_nettype wire

// File: tb/tb_spatial_mac_array_4x4.sv
// ---------------------------------------------------------------------------
// tb_spatial_mac_array_4x4 : directed self-checking bench for the MAC array
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spatial_mac_array_4x4;

    logic        clk;
    logic        rst;
    logic [15:0] weight  [4][4];
    logic [15:0] inputt  [16];
    logic [31:0] outputt [16];

    int n_checks;
    int n_pass;

    spatial_mac_array_4x4 dut (
        .clk     (clk),
        .rst     (rst),
        .weight  (weight),
        .inputt  (inputt),
        .outputt (outputt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare every PE against mult*(i+1)^2, skipping index 'skip' (-1 = none).
    task automatic check_squares(input string tag, input int mult, input int skip);
        for (int i = 0; i < 16; i++) begin
            if (i != skip) begin
                check($sformatf("%s[%0d]", tag, i), outputt[i], 32'(mult * (i+1) * (i+1)));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s[%0d]", tag, i), outputt[i], 32'd0);
        end
    endtask

    task automatic load_ramp();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                weight[r][c] = 16'(4*r + c + 1);
                inputt[4*r + c] = 16'(4*r + c + 1);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            weight[i/4][i%4] = 16'($urandom);
            inputt[i]        = 16'($urandom);
        end

        // Reset held across several edges with arbitrary inputs.
        repeat (3) step();
        check_zero("reset_hold");

        // Single step, then accumulate twice more.
        load_ramp();
        rst = 1'b1;
        step();
        check_squares("step1", 1, -1);
        step();
        check_squares("step2", 2, -1);
        step();
        check_squares("step3", 3, -1);

        // Asynchronous clear between edges, then held over an edge.
        rst = 1'b0;
        #1;
        check_zero("async_clr");
        step();
        check_zero("clr_edge");

        // Release after mid-run reset gives 1x again.
        rst = 1'b1;
        step();
        check_squares("rerun1", 1, -1);

        // Zero weight on PE 6: it holds at 49 while others keep accumulating.
        weight[1][2] = 16'd0;
        step();
        check("hold6", outputt[6], 32'd49);
        check_squares("iso2", 2, 6);

        // Mid-cycle input change has no visible effect before the edge.
        for (int i = 0; i < 16; i++) inputt[i] = 16'(2*(i+1));
        #3;
        check("midcyc0", outputt[0], 32'd2);
        check("midcyc15", outputt[15], 32'd512);
        check("midcyc6", outputt[6], 32'd49);
        step();
        check_squares("iso4", 4, 6);
        check("hold6_b", outputt[6], 32'd49);

        // Overflow wrap on PE 0, neighbours unaffected.
        rst = 1'b0;
        #1;
        load_ramp();
        weight[0][0] = 16'hFFFF;
        inputt[0]    = 16'hFFFF;
        rst = 1'b1;
        step();
        check("ovf_e1", outputt[0], 32'hFFFE0001);
        check("ovf_e1_pe1", outputt[1], 32'd4);
        check("ovf_e1_pe15", outputt[15], 32'd256);
        step();
        check("ovf_e2", outputt[0], 32'hFFFC0002);
        check("ovf_e2_pe5", outputt[5], 32'd72);
        check("ovf_e2_pe15", outputt[15], 32'd512);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_spatial_mac_array_4x4

`default_nettype wire
